// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_pkg
//  Description : Shared constants and helpers for the multi-bank SRAM buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package sram_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    localparam int c_DEF_ADDR_WIDTH = 9;
    localparam int c_DEF_NUM_BANK   = 4;
    localparam int BANK_BITS        = clog2(c_DEF_NUM_BANK);
    localparam int ROW_BITS         = c_DEF_ADDR_WIDTH - BANK_BITS;

    // One byte enable widened to the eight bit enables it governs.
    function automatic logic [7:0] mask_expand(input logic byte_en);
        return {8{byte_en}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_sp_mask.sv
`default_nettype none
// ============================================================================
//  Module      : sram_sp_mask
//  Description : Behavioural single-port bank with active-low bit write mask.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_sp_mask #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  CK,
    input  logic                  CSB,
    input  logic                  WEB,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] DI,
    input  logic [DATA_WIDTH-1:0] BWEB,
    output logic [DATA_WIDTH-1:0] DO
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] r_do;

    // BWEB bit = 0 writes that bit; DO only updates on a read access.
    always_ff @(posedge CK) begin
        if (!CSB) begin
            if (!WEB) begin
                r_mem[A] <= (r_mem[A] & BWEB) | (DI & ~BWEB);
            end else begin
                r_do <= r_mem[A];
            end
        end
    end

    assign DO = r_do;

endmodule
`default_nettype wire

// File: rtl/sram_mbank.sv
`default_nettype none
// ============================================================================
//  Module      : sram_mbank
//  Description : Address-interleaved multi-bank buffer, 1W + 1R with arbitration.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_mbank
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 128,
    parameter int NUM_BANK   = 4
) (
    input  logic                    CK,
    input  logic                    rst_n,
    input  logic                    wr_req,
    output logic                    wr_rdy,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_mask,
    input  logic                    rd_req,
    output logic                    rd_rdy,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic                    rd_dval,
    output logic [DATA_WIDTH-1:0]   rd_data
);

    localparam int c_bank_bits  = clog2(NUM_BANK);
    localparam int c_row_bits   = ADDR_WIDTH - c_bank_bits;
    localparam int c_mask_width = DATA_WIDTH / 8;

    logic [c_bank_bits-1:0] w_wr_bank;
    logic [c_bank_bits-1:0] w_rd_bank;
    logic [c_row_bits-1:0]  w_wr_row;
    logic [c_row_bits-1:0]  w_rd_row;
    logic                   w_conflict;
    logic [DATA_WIDTH-1:0]  w_bweb;
    logic [DATA_WIDTH-1:0]  w_bank_do [NUM_BANK];

    logic                   r_prio;
    logic                   r_rd_vld;
    logic [c_bank_bits-1:0] r_rd_bank;
    logic                   r_rd_dval;
    logic [DATA_WIDTH-1:0]  r_rd_data;

    assign w_wr_bank = wr_addr[c_bank_bits-1:0];
    assign w_rd_bank = rd_addr[c_bank_bits-1:0];
    assign w_wr_row  = wr_addr[ADDR_WIDTH-1:c_bank_bits];
    assign w_rd_row  = rd_addr[ADDR_WIDTH-1:c_bank_bits];

    // Grants are suppressed in reset so no bank is touched.
    assign w_conflict = rst_n & wr_req & rd_req & (w_wr_bank == w_rd_bank);
    assign wr_rdy     = rst_n & wr_req & ~(w_conflict &  r_prio);
    assign rd_rdy     = rst_n & rd_req & ~(w_conflict & ~r_prio);

    always_comb begin
        w_bweb = '1;
        for (int i = 0; i < c_mask_width; i++) begin
            w_bweb[i*8 +: 8] = ~mask_expand(wr_mask[i]);
        end
    end

    generate
        for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
            logic w_wr_sel;
            logic w_rd_sel;

            assign w_wr_sel = wr_rdy & (w_wr_bank == c_bank_bits'(b));
            assign w_rd_sel = rd_rdy & (w_rd_bank == c_bank_bits'(b));

            sram_sp_mask #(
                .ADDR_WIDTH (c_row_bits),
                .DATA_WIDTH (DATA_WIDTH)
            ) u_bank (
                .CK   (CK),
                .CSB  (~(w_wr_sel | w_rd_sel)),
                .WEB  (~w_wr_sel),
                .A    (w_wr_sel ? w_wr_row : w_rd_row),
                .DI   (wr_data),
                .BWEB (w_bweb),
                .DO   (w_bank_do[b])
            );
        end
    endgenerate

    always_ff @(posedge CK) begin
        if (!rst_n) begin
            r_prio    <= 1'b0;
            r_rd_vld  <= 1'b0;
            r_rd_bank <= '0;
            r_rd_dval <= 1'b0;
            r_rd_data <= '0;
        end else begin
            if (w_conflict) begin
                r_prio <= ~r_prio;
            end
            r_rd_vld <= rd_rdy;
            if (rd_rdy) begin
                r_rd_bank <= w_rd_bank;
            end
            r_rd_dval <= r_rd_vld;
            if (r_rd_vld) begin
                r_rd_data <= w_bank_do[r_rd_bank];
            end
        end
    end

    assign rd_dval = r_rd_dval;
    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: doc/sram_mbank.md
# sram_mbank

Parametrised multi-bank on-chip buffer for the global-buffer path: a single-port SRAM array split into NUM_BANK address-interleaved banks, with one independent write port and one independent read port, both using request/ready handshakes. Per-byte write masking is supported. Same-bank conflicts are resolved with alternating priority, and read data is returned with a data-valid strobe after a fixed latency. The block sits between the GB controller and the PE-array feeders. It supersedes direct instantiation of single-bank SRAM models.

## Interface
Parameters:
- ADDR_WIDTH, 9: total word address width; total depth = 2^ADDR_WIDTH words.
- DATA_WIDTH, 128: word width; must be a multiple of 8.
- NUM_BANK, 4: bank count; power of 2, at least 2 and at most 2^(ADDR_WIDTH-1).

Ports (one clock; reset is synchronous and active-low):
- CK  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset, sampled on posedge CK.
- wr_req  in  1  write request.
- wr_rdy  out  1  write granted this cycle; the write completes when wr_req && wr_rdy.
- wr_addr  in  ADDR_WIDTH  write word address.
- wr_data  in  DATA_WIDTH  write data.
- wr_mask  in  DATA_WIDTH/8  byte enables; 1 = write that byte.
- rd_req  in  1  read request.
- rd_rdy  out  1  read granted this cycle.
- rd_addr  in  ADDR_WIDTH  read word address.
- rd_dval  out  1  rd_data valid; a 1-cycle pulse per granted read.
- rd_data  out  DATA_WIDTH  read data, registered.

## Operation
- Bank mapping:
  - bank = addr[log2(NUM_BANK)-1:0]
  - row = addr[ADDR_WIDTH-1:log2(NUM_BANK)]
  - Each bank holds 2^ADDR_WIDTH/NUM_BANK rows.
- No conflict (only one request active, or requests target different banks): every active request is granted in the same cycle. wr_rdy = wr_req and rd_rdy = rd_req.
- Conflict (both requests active, same bank):
  - Exactly one is granted, selected by the 1-bit register prio (0 = write wins, 1 = read wins).
  - prio toggles on every conflict cycle. It is unchanged on non-conflict cycles.
  - The losing requester must hold its request; it wins the next conflict.
- rdy outputs are combinational from req, addr and prio. A requester may drop a request without it being granted.
- Masked write: only bytes with wr_mask[i]=1 are updated. If wr_mask = 0, no byte changes, but the bank is still occupied for that cycle.
- Memory contents are not reset and are undefined until written. rst_n does not clear memory.
- Read data pipeline:
  - Cycle t: grant; the bank is accessed at the posedge ending cycle t.
  - Cycle t+1: the bank-select pipeline register selects the bank output.
  - Cycle t+2: the selected data is registered into rd_data and rd_dval=1.
- rd_data holds its last value while rd_dval=0.
- Reset values: rd_dval=0, rd_data=0, prio=0, pipeline valid/bank-select registers = 0.
- While rst_n=0: wr_rdy=0 and rd_rdy=0, so no memory access occurs.

## Timing
- Read latency is exactly 2 cycles from the grant edge to rd_dval. Throughput is 1 read and 1 write per cycle when the banks differ.
- Write-then-read to the same address:
  - Write granted in cycle t, read granted in t+1 or later: the read returns the new data.
  - Same-cycle same-address requests are always a conflict, so they serialise. Ordering follows prio.
- Back-to-back reads from the same bank: granted every cycle, with rd_dval high continuously 2 cycles later.
- Reset mid-operation: in-flight reads are discarded, and rd_dval=0 from the first cycle after the reset edge. Any write granted in the cycle before reset asserts is retained.

## Structure
- Shared package sram_pkg:
  - constant function clog2
  - derived localparams BANK_BITS and ROW_BITS
  - function mask_expand (byte mask to bit mask)
- Sub-module sram_sp_mask: a behavioural single-port bank with the signals A, DI, DO, WEB, CSB, CK and bit-mask BWEB, registered DO, no reset. It is instantiated NUM_BANK times through a generate loop.
- The top level contains the arbitration, the prio register, the read pipeline and the output mux.

## Test plan
- Reset, then write 0x...A5 (all bytes) to addr 5 and read addr 5 later → rd_dval 2 cycles after the rd grant, rd_data = 0x...A5.
- Write addr 0 and read addr 1 simultaneously (banks 0 and 1) → both rdy=1 in the same cycle; read data returned at +2.
- Hold wr_req to addr 4 and rd_req to addr 8 (both bank 0) for 4 cycles → grants alternate W,R,W,R, starting with the write after reset.
- Write 0xFF..FF to addr 3, then write 0x00..00 with wr_mask = 0x0001 → read returns 0xFF..FF00.
- Stream 16 reads to addresses 0..15 on consecutive cycles → 16 consecutive rd_dval pulses with data in address order.
- Assert rst_n=0 one cycle after a read grant → no rd_dval; rd_data=0; memory is intact on a re-read.
